// File: rtl/cdb_arbiter_mp.sv
// rtl/cdb_arbiter_mp.sv - multi-lane CDB arbiter, fixed-priority or round-robin grant
// Grants up to N_CDB done FUs per cycle; granted tag/value pairs are broadcast on registered lanes.
module cdb_arbiter_mp #(
    parameter int N_FU    = 5,
    parameter int N_CDB   = 2,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 3,
    parameter int RR_MODE = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [N_FU-1:0]         fu_done,
    input  logic [N_FU*XLEN-1:0]    fu_value,
    input  logic [N_FU*TAG_W-1:0]   fu_tag,
    output logic [N_FU-1:0]         fu_ack,
    output logic [N_CDB-1:0]        cdb_valid,
    output logic [N_CDB*TAG_W-1:0]  cdb_tag,
    output logic [N_CDB*XLEN-1:0]   cdb_value
);
    localparam int PTR_W = $clog2(N_FU);
    localparam int CNT_W = $clog2(N_FU + 1);

    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [N_CDB-1:0]       valid_q, valid_d;
    logic [N_CDB*TAG_W-1:0] tag_q, tag_d;
    logic [N_CDB*XLEN-1:0]  value_q, value_d;

    logic [PTR_W-1:0]       pos  [N_FU];
    logic [CNT_W-1:0]       rank [N_FU];
    logic [N_FU-1:0]        grant;
    logic [PTR_W-1:0]       last_idx;
    logic [PTR_W-1:0]       last_pos;

    // pos[i] is FU i's place in this cycle's search order; rank[i] counts requesters ahead of it.
    always_comb begin
        for (int i = 0; i < N_FU; i++) begin
            if (RR_MODE != 0) begin
                if (PTR_W'(i) >= ptr_q) begin
                    pos[i] = PTR_W'(i) - ptr_q;
                end else begin
                    pos[i] = PTR_W'(i) + PTR_W'(N_FU) - ptr_q;
                end
            end else begin
                pos[i] = PTR_W'(N_FU - 1 - i);
            end
        end

        for (int i = 0; i < N_FU; i++) begin
            rank[i] = '0;
            for (int m = 0; m < N_FU; m++) begin
                if (m != i && fu_done[m] && pos[m] < pos[i]) begin
                    rank[i] = rank[i] + CNT_W'(1);
                end
            end
            grant[i] = !clear && fu_done[i] && (rank[i] < CNT_W'(N_CDB));
        end

        last_idx = '0;
        last_pos = '0;
        for (int i = 0; i < N_FU; i++) begin
            if (grant[i] && pos[i] >= last_pos) begin
                last_pos = pos[i];
                last_idx = PTR_W'(i);
            end
        end

        if (clear) begin
            ptr_d = '0;
        end else if (|grant) begin
            ptr_d = (last_idx == PTR_W'(N_FU - 1)) ? '0 : last_idx + PTR_W'(1);
        end else begin
            ptr_d = ptr_q;
        end

        valid_d = '0;
        tag_d   = '0;
        value_d = '0;
        for (int k = 0; k < N_CDB; k++) begin
            for (int i = 0; i < N_FU; i++) begin
                if (grant[i] && rank[i] == CNT_W'(k)) begin
                    valid_d[k]                  = 1'b1;
                    tag_d[k*TAG_W +: TAG_W]     = fu_tag[i*TAG_W +: TAG_W];
                    value_d[k*XLEN +: XLEN]     = fu_value[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Reset gates only the combinational ack; the flops are already held by the async reset.
    assign fu_ack = reset ? grant : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q   <= '0;
            valid_q <= '0;
            tag_q   <= '0;
            value_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            value_q <= value_d;
        end
    end

    assign cdb_valid = valid_q;
    assign cdb_tag   = tag_q;
    assign cdb_value = value_q;
endmodule

// File: tb/tb_cdb_arbiter_mp.sv
// tb/tb_cdb_arbiter_mp.sv - scoreboard bench for cdb_arbiter_mp in three configurations
module tb_cdb_arbiter_mp;
    typedef struct packed {
        logic [1:0]  v;
        logic [5:0]  t;
        logic [63:0] val;
    } lane_t;

    logic          clock;
    logic          reset;
    logic          clear;
    logic [4:0]    done_m, done_l, done_r;
    logic [159:0]  fu_value;
    logic [14:0]   fu_tag;
    logic [31:0]   vl [5];
    logic [2:0]    tg [5];

    logic [4:0]    ack_m, ack_l, ack_r;
    logic [1:0]    cv_m;
    logic [5:0]    ct_m;
    logic [63:0]   cval_m;
    logic [0:0]    cv_l, cv_r;
    logic [2:0]    ct_l, ct_r;
    logic [31:0]   cval_l, cval_r;

    int            total = 0;
    int            bad = 0;
    lane_t         exp_q [$];
    int            ptr_m [3];
    logic [4:0]    mack [3];
    logic [4:0]    pend;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            fu_value[i*32 +: 32] = vl[i];
            fu_tag[i*3 +: 3]     = tg[i];
        end
    end

    cdb_arbiter_mp #(.N_FU(5), .N_CDB(2), .XLEN(32), .TAG_W(3), .RR_MODE(1)) u_mp (
        .clock(clock), .reset(reset), .clear(clear), .fu_done(done_m),
        .fu_value(fu_value), .fu_tag(fu_tag), .fu_ack(ack_m),
        .cdb_valid(cv_m), .cdb_tag(ct_m), .cdb_value(cval_m));

    cdb_arbiter_mp #(.N_FU(5), .N_CDB(1), .XLEN(32), .TAG_W(3), .RR_MODE(0)) u_lg (
        .clock(clock), .reset(reset), .clear(clear), .fu_done(done_l),
        .fu_value(fu_value), .fu_tag(fu_tag), .fu_ack(ack_l),
        .cdb_valid(cv_l), .cdb_tag(ct_l), .cdb_value(cval_l));

    cdb_arbiter_mp #(.N_FU(5), .N_CDB(1), .XLEN(32), .TAG_W(3), .RR_MODE(1)) u_r1 (
        .clock(clock), .reset(reset), .clear(clear), .fu_done(done_r),
        .fu_value(fu_value), .fu_tag(fu_tag), .fu_ack(ack_r),
        .cdb_valid(cv_r), .cdb_tag(ct_r), .cdb_value(cval_r));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: walk the search order explicitly and fill lanes in grant order.
    task automatic model(input logic [4:0] done, input int ncdb, input bit rr, input int ptr,
                         output logic [4:0] ack, output lane_t e, output int nptr);
        int n;
        int idx;
        int last;
        ack  = '0;
        e    = '0;
        n    = 0;
        last = -1;
        nptr = ptr;
        if (!reset || clear) begin
            nptr = 0;
        end else begin
            for (int j = 0; j < 5; j++) begin
                idx = rr ? (ptr + j) % 5 : 4 - j;
                if (done[idx] && n < ncdb) begin
                    ack[idx]          = 1'b1;
                    e.v[n]            = 1'b1;
                    e.t[n*3 +: 3]     = tg[idx];
                    e.val[n*32 +: 32] = vl[idx];
                    last = idx;
                    n++;
                end
            end
            if (last >= 0) nptr = (last + 1) % 5;
        end
    endtask

    task automatic sb_step(input int id, input int ncdb, input bit rr, input logic [4:0] done,
                           input logic [4:0] ack_g, input logic [1:0] v_g, input logic [5:0] t_g,
                           input logic [63:0] val_g);
        lane_t e;
        lane_t e2;
        logic [4:0] a;
        int np;
        if (exp_q.size() == 0) begin
            chk($sformatf("sb_empty%0d", id), 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("lane_valid%0d", id), 64'(v_g), 64'(e.v));
            chk($sformatf("lane_tag%0d", id), 64'(t_g), 64'(e.t));
            chk($sformatf("lane_value%0d", id), val_g, e.val);
        end
        model(done, ncdb, rr, ptr_m[id], a, e2, np);
        chk($sformatf("ack%0d", id), 64'(ack_g), 64'(a));
        exp_q.push_back(e2);
        ptr_m[id] = np;
        mack[id]  = a;
    endtask

    task automatic cyc();
        @(negedge clock);
        sb_step(0, 2, 1'b1, done_m, ack_m, cv_m, ct_m, cval_m);
        sb_step(1, 1, 1'b0, done_l, ack_l, {1'b0, cv_l}, {3'b0, ct_l}, {32'b0, cval_l});
        sb_step(2, 1, 1'b1, done_r, ack_r, {1'b0, cv_r}, {3'b0, ct_r}, {32'b0, cval_r});
        @(posedge clock);
        #1;
    endtask

    task automatic drop_acked();
        done_m = done_m & ~mack[0];
        done_l = done_l & ~mack[1];
        done_r = done_r & ~mack[2];
    endtask

    initial begin
        reset  = 1'b0;
        clear  = 1'b0;
        done_m = 5'b11111;
        done_l = 5'b01100;
        done_r = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            vl[i] = 32'(10 * (i + 1));
            tg[i] = 3'(i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            ptr_m[i] = 0;
            mack[i]  = '0;
        end
        #2;
        chk("rst_ack_m", 64'(ack_m), 64'd0);
        chk("rst_ack_l", 64'(ack_l), 64'd0);
        chk("rst_valid", 64'(cv_m), 64'd0);
        chk("rst_tag", 64'(ct_m), 64'd0);
        chk("rst_value", cval_m, 64'd0);
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
        cyc();
        cyc();

        reset = 1'b1;
        #1;
        chk("rel_ack_m", 64'(ack_m), 64'(5'b00011));
        chk("legacy_ack", 64'(ack_l), 64'(5'b01000));
        chk("rr1_ack0", 64'(ack_r), 64'(5'b00001));
        cyc();
        drop_acked();
        done_r = 5'b11111;
        #1;
        chk("two_lane_tags", 64'(ct_m), 64'(6'b010_001));
        chk("two_lane_vals", cval_m, {32'd20, 32'd10});
        chk("legacy_tag4", 64'(ct_l), 64'd4);
        chk("legacy_val40", 64'(cval_l), 64'd40);
        chk("two_lane_ack1", 64'(ack_m), 64'(5'b01100));
        chk("legacy_ack2", 64'(ack_l), 64'(5'b00100));
        chk("rr1_ack1", 64'(ack_r), 64'(5'b00010));
        cyc();
        drop_acked();
        done_r = 5'b11111;
        #1;
        chk("two_lane_ack2", 64'(ack_m), 64'(5'b10000));
        chk("legacy_tag3", 64'(ct_l), 64'd3);
        chk("legacy_val30", 64'(cval_l), 64'd30);
        chk("rr1_ack2", 64'(ack_r), 64'(5'b00100));
        cyc();
        drop_acked();
        done_r = 5'b11111;
        done_m = 5'b11111;
        #1;
        chk("lane1_idle", 64'(cv_m), 64'(2'b01));
        chk("ptr_wrapped0", 64'(ack_m), 64'(5'b00011));
        chk("rr1_ack3", 64'(ack_r), 64'(5'b01000));
        cyc();
        drop_acked();
        done_r = 5'b11111;
        #1;
        chk("rr1_ack4", 64'(ack_r), 64'(5'b10000));
        cyc();
        drop_acked();
        done_r = 5'b11111;
        #1;
        chk("rr1_wrap", 64'(ack_r), 64'(5'b00001));
        cyc();
        drop_acked();
        done_r = 5'b11111;
        #1;
        chk("rr1_ack6", 64'(ack_r), 64'(5'b00010));
        cyc();
        drop_acked();
        done_r = 5'b11111;

        done_m = 5'b00110;
        clear  = 1'b1;
        #1;
        chk("clear_ack", 64'(ack_m), 64'd0);
        cyc();
        clear = 1'b0;
        #1;
        chk("clear_lanes", 64'(cv_m), 64'd0);
        chk("after_clear_ack", 64'(ack_m), 64'(5'b00110));
        chk("after_clear_rr1", 64'(ack_r), 64'(5'b00001));
        cyc();
        drop_acked();
        chk("pre_async_tag2", 64'(ct_m[2:0]), 64'd2);
        #1;
        reset = 1'b0;
        #1;
        chk("async_valid", 64'(cv_m), 64'd0);
        chk("async_tag", 64'(ct_m), 64'd0);
        chk("async_value", cval_m, 64'd0);
        chk("async_legacy_valid", 64'(cv_l), 64'd0);
        for (int i = 0; i < exp_q.size(); i++) exp_q[i] = '0;
        for (int i = 0; i < 3; i++) ptr_m[i] = 0;
        cyc();
        reset = 1'b1;

        for (int c = 0; c < 50; c++) begin
            cyc();
            if (clear) begin
                done_m = '0;
                done_l = '0;
                done_r = '0;
                clear  = 1'b0;
            end else begin
                drop_acked();
            end
            pend = done_m | done_l | done_r;
            for (int i = 0; i < 5; i++) begin
                if (!pend[i]) begin
                    vl[i] = $urandom;
                    tg[i] = 3'($urandom_range(0, 7));
                end
            end
            done_m = done_m | 5'($urandom_range(0, 31));
            done_l = done_l | 5'($urandom_range(0, 31));
            done_r = done_r | 5'($urandom_range(0, 31));
            clear  = ($urandom_range(0, 9) == 0);
        end
        clear = 1'b0;
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter_mp.md
# cdb_arbiter_mp

Parametrised multi-lane common data bus (CDB) arbiter.
- Collects completed results from `N_FU` functional units.
- Each cycle, grants up to `N_CDB` of them under fixed-priority or round-robin policy and acknowledges the granted units.
- Broadcasts granted tag/value pairs on registered CDB lanes one cycle later to the RS, ROB and map table.
- Generalises the single-lane fixed-priority CDB; with `N_CDB=1, RR_MODE=0` it is cycle-equivalent to it.

## Interface
Parameters:
- `N_FU`, 5, number of requesting functional units (≥2)
- `N_CDB`, 2, number of broadcast lanes (1 ≤ N_CDB ≤ N_FU)
- `XLEN`, 32, result width
- `TAG_W`, 3, ROB tag width
- `RR_MODE`, 1, 0 = fixed priority (highest FU index wins), 1 = round-robin

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low (asserted at 0)
- `clear`  in  1  synchronous flush (mispredict squash)
- `fu_done`  in  N_FU  FU i holds a result
- `fu_value`  in  N_FU*XLEN  FU i result in bits [i*XLEN +: XLEN]
- `fu_tag`  in  N_FU*TAG_W  FU i ROB tag in bits [i*TAG_W +: TAG_W]
- `fu_ack`  out  N_FU  combinational grant; FU i may drop its result after this edge
- `cdb_valid`  out  N_CDB  registered lane-valid
- `cdb_tag`  out  N_CDB*TAG_W  registered lane tags, lane k in [k*TAG_W +: TAG_W]
- `cdb_value`  out  N_CDB*XLEN  registered lane values, lane k in [k*XLEN +: XLEN]

## Operation
- **Request/hold rule:** an FU drives `fu_done`/value/tag and holds them unchanged until it sees `fu_ack[i]=1` at a rising edge. An un-acked request persists; the arbiter never loses it.
- **Grant search:** scans up to `N_CDB` requesters in priority order. The k-th granted FU goes to lane k. `fu_ack` is one-hot per granted FU and has popcount ≤ `N_CDB`.
- **Fixed mode (`RR_MODE=0`):** order is N_FU-1 down to 0.
- **Round-robin mode (`RR_MODE=1`):** order is ptr, ptr+1, …, wrapping mod N_FU.
  - ptr is a $clog2(N_FU)-bit register.
  - On any grant: ptr ← (last granted index + 1) mod N_FU, wrapping at N_FU, not at a power of two.
  - With no grant, ptr holds.
- **Lane registers:** on each edge, granted lanes load valid=1 with the granted tag/value. Ungranted lanes load valid=0, tag=0, value=0.
- **clear=1:**
  - `fu_ack` forced 0 that cycle.
  - At the edge, all lane registers are zeroed and ptr ← 0.
  - FUs are flushed externally; the arbiter keeps no other state.
- **Reset (`reset`=0):**
  - Immediately and asynchronously: `cdb_valid`/`cdb_tag`/`cdb_value` = 0 and ptr = 0.
  - `fu_ack` = 0 while reset is asserted.
  - Reset dominates `clear`.
- **N_CDB = N_FU:** every requester is granted every cycle; ptr still updates.

## Timing
- Done-to-broadcast latency is one cycle: `fu_done[i]`=1 and `fu_ack[i]`=1 in cycle t → lane data valid for the whole of cycle t+1.
- A result that is never granted waits indefinitely in fixed mode. In RR mode the worst-case wait is ⌈(N_FU−1)/N_CDB⌉ cycles.
- `fu_ack` depends combinationally on `fu_done`, ptr, `clear` and `reset` only, never on `fu_value`.
- A lane's `cdb_valid` is held exactly one cycle per grant; back-to-back grants give consecutive valid cycles.
- Reset release is sampled at the next rising edge. The first legal grant is in the first cycle with `reset`=1.

## Test plan
- **Reset:**
  - Drive `reset`=0 with `fu_done`=11111 → all `cdb_*`=0 and `fu_ack`=0 without waiting for a clock edge.
  - Release reset → first edge grants FU0,FU1 (RR, N_CDB=2).
- **Legacy equivalence (N_CDB=1, RR_MODE=0):**
  - Stimulus: `fu_done`=01100, values {50,40,30,20,10}, tags {5,4,3,2,1}.
  - Required: `fu_ack`=01000; next cycle `cdb_tag`=4, `cdb_value`=40, `cdb_valid`=1.
  - Hold `fu_done`=00100 → then tag 3 / value 30.
- **Round-robin wrap (N_CDB=1, RR):** `fu_done`=11111 held, re-asserting each FU after its ack → grant order 0,1,2,3,4,0,1; ptr wraps 4→0.
- **Two-lane RR (N_CDB=2):** 11111 from ptr=0, FUs dropping on ack.
  - Cycle 0: `fu_ack`=00011; next cycle lane0=FU0, lane1=FU1.
  - Cycle 1: `fu_ack`=01100.
  - Cycle 2: `fu_ack`=10000; lane1 valid=0 the following cycle; ptr=0.
- **Clear:** `fu_done`=00110 with `clear`=1 → `fu_ack`=00000; next cycle `cdb_valid`=00 and ptr=0; clear=0 next cycle → ack 00110.
- **Async reset mid-broadcast:** lane0 valid with tag 2; drop `reset` between edges → `cdb_valid`/tag/value = 0 immediately, before the next rising edge.
